// File: rtl/uart_tx.sv
// UART transmitter: accepts one W_OUT-bit word through a valid/ready handshake
// and sends it on tx as W_OUT/BITS_PER_WORD back-to-back UART packets, word 0 first.
// Each packet is a start bit (0), the data bits LSB first, then stop/padding bits of 1.
module uart_tx #(
   parameter int CLOCKS_PER_PULSE = 20833,
   parameter int BITS_PER_WORD    = 8,
   parameter int PACKET_SIZE      = BITS_PER_WORD + 5,
   parameter int W_OUT            = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             s_valid,
   input  logic [W_OUT-1:0] s_data,
   output logic             s_ready,
   output logic             tx
);

   localparam int NUM_WORDS  = W_OUT / BITS_PER_WORD;
   localparam int TOTAL_BITS = NUM_WORDS * PACKET_SIZE;
   localparam int CNT_W      = $clog2(CLOCKS_PER_PULSE);
   localparam int BIT_W      = $clog2(TOTAL_BITS);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TOTAL_BITS - 1);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t                  state;
   logic [TOTAL_BITS-1:0]   frame;
   // Holds the bits still to be sent; bit 0 of the frame goes straight into tx.
   logic [TOTAL_BITS-2:0]   shreg;
   logic [CNT_W-1:0]        clk_cnt;
   logic [BIT_W-1:0]        bit_cnt;

   // Build all framed packets from the incoming word; padding bits default to 1.
   always_comb begin
      // NOTE: assigning a full default first keeps every bit driven on every pass, so no latch is inferred.
      frame = '1;
      for (int w = 0; w < NUM_WORDS; w++) begin
         frame[w*PACKET_SIZE] = 1'b0;
         frame[w*PACKET_SIZE+1 +: BITS_PER_WORD] = s_data[w*BITS_PER_WORD +: BITS_PER_WORD];
      end
   end

   // Handshake, bit timing and serialization; tx and s_ready come straight from flops.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         s_ready <= 1'b1;
         tx      <= 1'b1;
         shreg   <= '1;
         clk_cnt <= '0;
         bit_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples values from before this edge.
         case (state)
            IDLE: begin
               if (s_valid) begin
                  state   <= SEND;
                  s_ready <= 1'b0;
                  tx      <= frame[0];
                  shreg   <= frame[TOTAL_BITS-1:1];
                  clk_cnt <= '0;
                  bit_cnt <= '0;
               end
            end
            SEND: begin
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     state   <= IDLE;
                     s_ready <= 1'b1;
                     tx      <= 1'b1;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     tx      <= shreg[0];
                     shreg   <= {1'b1, shreg[TOTAL_BITS-2:1]};
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               s_ready <= 1'b1;
               tx      <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: stimulus pushes each accepted word into a queue, and an
// independent line monitor decodes tx mid-bit, checks framing and pops/compares words.
module tb_uart_tx;

   localparam int CPP   = 4;
   localparam int BPW   = 8;
   localparam int PKT   = 13;
   localparam int WOUT  = 16;
   localparam int NW    = WOUT / BPW;
   localparam int TOTAL = NW * PKT;

   logic            clk;
   logic            rstn;
   logic            s_valid;
   logic [WOUT-1:0] s_data;
   logic            s_ready;
   logic            tx;

   int n_tests = 0;
   int n_fail  = 0;
   int n_frames = 0;

   logic [WOUT-1:0] exp_q[$];
   bit              mon_busy = 0;

   uart_tx #(
      .CLOCKS_PER_PULSE(CPP),
      .BITS_PER_WORD   (BPW),
      .PACKET_SIZE     (PKT),
      .W_OUT           (WOUT)
   ) dut (
      .clk    (clk),
      .rstn   (rstn),
      .s_valid(s_valid),
      .s_data (s_data),
      .s_ready(s_ready),
      .tx     (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Line monitor: detects a start bit, samples every bit mid-way, checks framing.
   initial begin
      int                 cyc;
      logic [TOTAL-1:0]   bits;
      logic [WOUT-1:0]    got;
      cyc  = 0;
      bits = '0;
      got  = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            mon_busy = 0;
            exp_q.delete();
         end else begin
            if (!mon_busy && tx == 1'b0) begin
               mon_busy = 1;
               cyc      = 0;
            end
            if (mon_busy) begin
               if (cyc % CPP == CPP / 2) begin
                  bits[cyc / CPP] = tx;
                  if (cyc / CPP == TOTAL - 1) begin
                     for (int w = 0; w < NW; w++) begin
                        check("start_bit", {31'd0, bits[w*PKT]}, 32'd0);
                        check("pad_bits", {28'd0, bits[w*PKT+BPW+1 +: PKT-BPW-1]}, 32'hF);
                        got[w*BPW +: BPW] = bits[w*PKT+1 +: BPW];
                     end
                     n_frames++;
                     mon_busy = 0;
                     if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL spurious_frame: got 0x%0h, expected no frame at %0t", got, $time);
                     end else begin
                        check("word", {16'd0, got}, {16'd0, exp_q.pop_front()});
                     end
                  end
               end
               cyc++;
            end
         end
      end
   end

   task automatic wait_ready(output bit ok);
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (s_ready) begin
            ok = 1;
            return;
         end
      end
      check("ready_timeout", {31'd0, s_ready}, 32'd1);
   endtask

   // Offer one word for a single cycle, `delay` cycles after s_ready is seen high.
   task automatic send(input logic [WOUT-1:0] w, input int delay);
      bit ok;
      wait_ready(ok);
      if (!ok) return;
      repeat (delay - 1) @(negedge clk);
      s_valid = 1'b1;
      s_data  = w;
      @(posedge clk);
      exp_q.push_back(w);
      #1;
      s_valid = 1'b0;
      s_data  = 16'hDEAD;
   endtask

   task automatic drain();
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !mon_busy && s_ready) return;
      end
      check("drain_timeout", exp_q.size(), 32'd0);
   endtask

   localparam logic [WOUT-1:0] RAND_WORDS [10] = '{
      16'h0000, 16'hFFFF, 16'h8001, 16'h1357, 16'hBEEF,
      16'h00FF, 16'hFF00, 16'h5555, 16'hAAAA, 16'hC0DE
   };
   localparam int RAND_DELAYS [10] = '{1, 20, 3, 1, 7, 12, 1, 5, 16, 2};

   initial begin
      bit ok_tx;
      bit ok_rdy;
      int busy;
      rstn    = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;

      // Reset: idle levels during and after reset, no line activity.
      repeat (2) @(negedge clk);
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_ready", {31'd0, s_ready}, 32'd1);
      rstn  = 1'b1;
      ok_tx  = 1;
      ok_rdy = 1;
      repeat (10) begin
         @(negedge clk);
         if (tx !== 1'b1) ok_tx = 0;
         if (s_ready !== 1'b1) ok_rdy = 0;
      end
      check("idle_tx_steady", {31'd0, ok_tx}, 32'd1);
      check("idle_ready_steady", {31'd0, ok_rdy}, 32'd1);

      // Single word: busy duration 2 packets * 13 bits * 4 cycles.
      send(16'hA53C, 1);
      check("start_after_accept", {31'd0, tx}, 32'd0);
      busy = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (s_ready) break;
         busy++;
      end
      check("busy_cycles", busy, 32'd104);
      drain();

      // Framing on another word.
      send(16'h7E81, 2);
      drain();

      // Busy-ignore: a pulse while transmitting must not be taken.
      send(16'h0001, 1);
      repeat (20) @(negedge clk);
      s_valid = 1'b1;
      s_data  = 16'hFFFF;
      @(negedge clk);
      s_valid = 1'b0;
      check("ready_while_busy", {31'd0, s_ready}, 32'd0);
      drain();

      // Ten words, back-to-back and spaced.
      for (int i = 0; i < 10; i++) send(RAND_WORDS[i], RAND_DELAYS[i]);
      drain();

      // Reset during word 0's data bits aborts at once.
      send(16'h5A5A, 1);
      repeat (6) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("abort_tx", {31'd0, tx}, 32'd1);
      check("abort_ready", {31'd0, s_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      send(16'h1234, 1);
      drain();

      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      check("frames_decoded", n_frames, 32'd14);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
